// File: rtl/alu_decode_stage.sv
// ---------------------------------------------------------------------------
// alu_decode_stage
//
// Purpose:
//   Decode/issue stage between fetch/register-read and execute. Each RV32I
//   instruction, together with its register-file read data, is decoded into
//   ALU operands (a, b), an ALU operation, destination-register information,
//   a branch-invert flag and an illegal-instruction flag. The result is held
//   in a registered valid/ready pipeline stage with one cycle of latency.
//
// Configuration:
//   ALU_DEC_SKID_EN  defined   -> two-entry (main + skid) buffer; in_ready is
//                                 a flop with no combinational path from
//                                 out_ready.
//                    undefined -> single output register; in_ready is
//                                 !out_valid || out_ready (combinational).
//
// Parameters:
//   RESET_PC_UNUSED  reserved, must stay 0; has no functional effect.
//
// Ports:
//   clk, rst           clock (rising edge) and async active-high reset
//   flush              synchronous kill of every buffered entry
//   in_valid/in_ready  upstream handshake
//   in_instr, in_pc    instruction word and its address
//   in_rs1_data/rs2    register-file read data
//   out_valid/ready    downstream handshake
//   out_op, out_a/b    ALU operation and operands
//   out_invert         downstream inverts ALU bit 0 (BGE/BGEU)
//   out_rd, out_rd_we  destination register and write enable
//   out_illegal        unsupported or malformed encoding
// ---------------------------------------------------------------------------

package alu_decode_pkg;

    typedef enum logic [3:0] {
        Add  = 4'd0,
        Sub  = 4'd1,
        Sll  = 4'd2,
        Slt  = 4'd3,
        Sltu = 4'd4,
        Xor  = 4'd5,
        Srl  = 4'd6,
        Sra  = 4'd7,
        Or   = 4'd8,
        And  = 4'd9,
        Eq   = 4'd10,
        Neq  = 4'd11
    } alu_ops;

    typedef struct packed {
        alu_ops      op;
        logic [31:0] a;
        logic [31:0] b;
        logic        invert;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } alu_dec_entry_t;

endpackage

module alu_decode_stage
    import alu_decode_pkg::*;
#(
    parameter int unsigned RESET_PC_UNUSED = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output alu_ops      out_op,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic        out_invert,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic        out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // The reserved parameter only feeds a reset value; it is required to be 0.
    localparam alu_dec_entry_t RESET_ENTRY = '{
        op:      Add,
        a:       32'(RESET_PC_UNUSED),
        b:       32'd0,
        invert:  1'b0,
        rd:      5'd0,
        rd_we:   1'b0,
        illegal: 1'b0
    };

    // Shared funct3 -> operation map of the register and immediate ALU groups.
    function automatic alu_ops base_op(input logic [2:0] f3);
        base_op = Add;
        case (f3)
            3'b000:  base_op = Add;
            3'b001:  base_op = Sll;
            3'b010:  base_op = Slt;
            3'b011:  base_op = Sltu;
            3'b100:  base_op = Xor;
            3'b101:  base_op = Srl;
            3'b110:  base_op = Or;
            default: base_op = And;
        endcase
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_idx;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] shamt;
    logic        unused_rs1_field;

    assign opcode = in_instr[6:0];
    assign rd_idx = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign shamt  = {27'b0, in_instr[24:20]};

    // Register indices are resolved upstream; only their data arrives here.
    assign unused_rs1_field = ^in_instr[19:15];

    alu_ops         dec_op;
    logic [31:0]    dec_a;
    logic [31:0]    dec_b;
    logic           dec_invert;
    logic           dec_writes;
    logic           dec_legal;
    alu_dec_entry_t dec_entry;

    // Raw decode: pick operation and operands per opcode group, and flag
    // anything outside the supported encodings as not legal.
    always_comb begin
        dec_op     = Add;
        dec_a      = in_rs1_data;
        dec_b      = in_rs2_data;
        dec_invert = 1'b0;
        dec_writes = 1'b0;
        dec_legal  = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec_writes = 1'b1;
                if (funct7 == F7_BASE) begin
                    dec_op = base_op(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_op = Sub;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_op = Sra;
                end else begin
                    dec_legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                dec_writes = 1'b1;
                dec_b      = imm_i;
                dec_op     = base_op(funct3);
                // Shift immediates carry funct7 in the upper immediate bits.
                if (funct3 == 3'b001) begin
                    dec_b = shamt;
                    if (funct7 != F7_BASE) begin
                        dec_legal = 1'b0;
                    end
                end else if (funct3 == 3'b101) begin
                    dec_b = shamt;
                    if (funct7 == F7_ALT) begin
                        dec_op = Sra;
                    end else if (funct7 != F7_BASE) begin
                        dec_legal = 1'b0;
                    end
                end
            end
            OPC_LUI: begin
                dec_writes = 1'b1;
                dec_a      = 32'd0;
                dec_b      = imm_u;
            end
            OPC_AUIPC: begin
                dec_writes = 1'b1;
                dec_a      = in_pc;
                dec_b      = imm_u;
            end
            OPC_LOAD: begin
                dec_writes = 1'b1;
                dec_b      = imm_i;
            end
            OPC_STORE: begin
                dec_b = imm_s;
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  dec_op = Eq;
                    3'b001:  dec_op = Neq;
                    3'b100:  dec_op = Slt;
                    3'b101: begin
                        dec_op     = Slt;
                        dec_invert = 1'b1;
                    end
                    3'b110:  dec_op = Sltu;
                    3'b111: begin
                        dec_op     = Sltu;
                        dec_invert = 1'b1;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Final entry: illegal encodings collapse to a harmless Add of zeros, and
    // out_rd is only reported for instructions that actually write a register.
    always_comb begin
        dec_entry         = RESET_ENTRY;
        dec_entry.op      = dec_legal ? dec_op : Add;
        dec_entry.a       = dec_legal ? dec_a : 32'd0;
        dec_entry.b       = dec_legal ? dec_b : 32'd0;
        dec_entry.invert  = dec_legal && dec_invert;
        dec_entry.rd      = (dec_legal && dec_writes) ? rd_idx : 5'd0;
        dec_entry.rd_we   = dec_legal && dec_writes && (rd_idx != 5'd0);
        dec_entry.illegal = !dec_legal;
    end

    alu_dec_entry_t main_q;
    alu_dec_entry_t main_d;
    logic           main_valid_q;
    logic           main_valid_d;
    logic           accept;
    logic           drain;

    // Inputs presented during a flush cycle are dropped.
    assign accept = in_valid && in_ready && !flush;
    assign drain  = main_valid_q && out_ready;

`ifdef ALU_DEC_SKID_EN
    alu_dec_entry_t skid_q;
    alu_dec_entry_t skid_d;
    logic           skid_valid_q;
    logic           skid_valid_d;
    logic           in_ready_q;
    logic           in_ready_d;

    assign in_ready = in_ready_q;

    // Main/skid steering. in_ready_q is low exactly when skid holds an entry,
    // so an accept can only occur while skid is empty.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (drain) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || drain) begin
                main_d       = dec_entry;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = dec_entry;
                skid_valid_d = 1'b1;
            end
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_q       <= RESET_ENTRY;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    // A single register can take a new entry whenever its current one leaves.
    assign in_ready = !main_valid_q || out_ready;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (accept) begin
            main_d       = dec_entry;
            main_valid_d = 1'b1;
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= RESET_ENTRY;
            main_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_op      = main_q.op;
    assign out_a       = main_q.a;
    assign out_b       = main_q.b;
    assign out_invert  = main_q.invert;
    assign out_rd      = main_q.rd;
    assign out_rd_we   = main_q.rd_we;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_decode_stage
//
// Scoreboard bench for alu_decode_stage. Stimulus pushes the hand-computed
// expected entry when the DUT accepts an instruction; a monitor on the
// falling edge compares every presented output with the queue head and pops
// it on a transfer. Build with or without ALU_DEC_SKID_EN to match the RTL.
// ---------------------------------------------------------------------------

module tb_alu_decode_stage;
    import alu_decode_pkg::*;

`ifdef ALU_DEC_SKID_EN
    localparam int STALL_ACCEPT = 2;
`else
    localparam int STALL_ACCEPT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        out_valid;
    logic        out_ready;
    alu_ops      out_op;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic        out_invert;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;
    alu_dec_entry_t sb[$];

    alu_decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_invert  (out_invert),
        .out_rd      (out_rd),
        .out_rd_we   (out_rd_we),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    function automatic alu_dec_entry_t mk(input alu_ops op, input logic [31:0] a,
                                          input logic [31:0] b, input logic inv,
                                          input logic [4:0] rd, input logic we,
                                          input logic ill);
        mk = '{op: op, a: a, b: b, invert: inv, rd: rd, rd_we: we, illegal: ill};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present one instruction until accepted, pushing its expectation.
    task automatic apply_stimulus(input logic [31:0] instr, input logic [31:0] pc,
                                  input logic [31:0] rs1, input logic [31:0] rs2,
                                  input alu_dec_entry_t exp);
        int guard;
        guard       = 0;
        in_valid    = 1'b1;
        in_instr    = instr;
        in_pc       = pc;
        in_rs1_data = rs1;
        in_rs2_data = rs2;
        while (1) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                break;
            end
            guard++;
            if (guard > 50) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout: instr %h never accepted", instr);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Stream n ADDIs; out_ready is held low for the first 'stall' cycles.
    task automatic stream(input int n, input int stall);
        int idx;
        int cyc;
        logic [31:0] k;
        idx = 0;
        cyc = 0;
        out_ready = (stall == 0);
        while (idx < n && cyc < 100) begin
            if (stall != 0 && cyc == stall) begin
                check_output("accepted_while_stalled", idx, STALL_ACCEPT);
                check_output("in_ready_while_stalled", {31'b0, in_ready}, 32'd0);
                out_ready = 1'b1;
            end
            k           = 32'(idx + 1);
            in_valid    = 1'b1;
            in_instr    = (k << 20) | (k << 7) | 32'h13;
            in_pc       = 32'h0;
            in_rs1_data = 32'h100 * k;
            in_rs2_data = 32'hDEAD;
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(mk(Add, 32'h100 * k, k, 1'b0, k[4:0], 1'b1, 1'b0));
                idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        check_output("stream_all_accepted", idx, n);
        if (stall == 0) check_output("throughput_cycles", cyc, n);
    endtask

    task automatic wait_drain();
        int guard;
        guard     = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check_output("scoreboard_drained", sb.size(), 0);
    endtask

    // Monitor: every presented entry must match the queue head; it is only
    // popped on a transfer, so stalled outputs are re-checked every cycle.
    always @(negedge clk) begin : monitor
        alu_dec_entry_t got;
        if (!rst && out_valid) begin
            got = mk(out_op, out_a, out_b, out_invert, out_rd, out_rd_we, out_illegal);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_output: got op=%0d a=%h b=%h rd=%0d, expected no entry",
                         got.op, got.a, got.b, got.rd);
            end else begin
                if (got !== sb[0]) begin
                    errors++;
                    $display("[TB] FAIL entry: got op=%0d a=%h b=%h inv=%b rd=%0d we=%b ill=%b, expected op=%0d a=%h b=%h inv=%b rd=%0d we=%b ill=%b",
                             got.op, got.a, got.b, got.invert, got.rd, got.rd_we, got.illegal,
                             sb[0].op, sb[0].a, sb[0].b, sb[0].invert, sb[0].rd, sb[0].rd_we, sb[0].illegal);
                end
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_instr    = 32'h0;
        in_pc       = 32'h0;
        in_rs1_data = 32'h0;
        in_rs2_data = 32'h0;
        out_ready   = 1'b0;

        #12;
        check_output("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("reset_out_op", {28'b0, out_op}, {28'b0, Add});
        check_output("reset_out_a", out_a, 32'd0);
        check_output("reset_out_b", out_b, 32'd0);
        check_output("reset_rd_flags", {25'b0, out_rd, out_rd_we, out_invert, out_illegal}, 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_output("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

        // Directed decode vectors, downstream always ready.
        out_ready = 1'b1;
        apply_stimulus(32'h00500093, 32'h0, 32'h0, 32'h0, mk(Add, 32'h0, 32'd5, 1'b0, 5'd1, 1'b1, 1'b0));
        apply_stimulus(32'h402081B3, 32'h0, 32'd10, 32'd3, mk(Sub, 32'd10, 32'd3, 1'b0, 5'd3, 1'b1, 1'b0));
        apply_stimulus(32'h40335293, 32'h0, 32'hF0000000, 32'h9, mk(Sra, 32'hF0000000, 32'd3, 1'b0, 5'd5, 1'b1, 1'b0));
        apply_stimulus(32'h0020D463, 32'h0, 32'd7, 32'd9, mk(Slt, 32'd7, 32'd9, 1'b1, 5'd0, 1'b0, 1'b0));
        apply_stimulus(32'h00000000, 32'h40, 32'h55, 32'h66, mk(Add, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1));
        apply_stimulus(32'h123453B7, 32'h0, 32'hDEAD, 32'h0, mk(Add, 32'h0, 32'h12345000, 1'b0, 5'd7, 1'b1, 1'b0));
        apply_stimulus(32'h00001117, 32'h80, 32'h1, 32'h2, mk(Add, 32'h80, 32'h1000, 1'b0, 5'd2, 1'b1, 1'b0));
        apply_stimulus(32'hFE20AE23, 32'h0, 32'h1000, 32'h77, mk(Add, 32'h1000, 32'hFFFFFFFC, 1'b0, 5'd0, 1'b0, 1'b0));
        apply_stimulus(32'h00100013, 32'h0, 32'h20, 32'h0, mk(Add, 32'h20, 32'd1, 1'b0, 5'd0, 1'b0, 1'b0));
        apply_stimulus(32'hFFF08213, 32'h0, 32'h30, 32'h0, mk(Add, 32'h30, 32'hFFFFFFFF, 1'b0, 5'd4, 1'b1, 1'b0));
        apply_stimulus(32'h00208463, 32'h0, 32'd1, 32'd2, mk(Eq, 32'd1, 32'd2, 1'b0, 5'd0, 1'b0, 1'b0));
        apply_stimulus(32'h00209463, 32'h0, 32'd1, 32'd2, mk(Neq, 32'd1, 32'd2, 1'b0, 5'd0, 1'b0, 1'b0));
        apply_stimulus(32'h0020F463, 32'h0, 32'd4, 32'd5, mk(Sltu, 32'd4, 32'd5, 1'b1, 5'd0, 1'b0, 1'b0));
        apply_stimulus(32'h0020A463, 32'h0, 32'd4, 32'd5, mk(Add, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1));
        apply_stimulus(32'h022081B3, 32'h0, 32'd4, 32'd5, mk(Add, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1));
        apply_stimulus(32'h0070B313, 32'h0, 32'h40, 32'h0, mk(Sltu, 32'h40, 32'd7, 1'b0, 5'd6, 1'b1, 1'b0));
        apply_stimulus(32'h40109093, 32'h0, 32'h40, 32'h0, mk(Add, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1));
        apply_stimulus(32'h00812403, 32'h0, 32'h100, 32'h0, mk(Add, 32'h100, 32'd8, 1'b0, 5'd8, 1'b1, 1'b0));
        apply_stimulus(32'h0020C4B3, 32'h0, 32'hF0F0, 32'h0FF0, mk(Xor, 32'hF0F0, 32'h0FF0, 1'b0, 5'd9, 1'b1, 1'b0));
        wait_drain();

        // Back-to-back throughput, then backpressure for three cycles.
        stream(4, 0);
        wait_drain();
        stream(4, 3);
        wait_drain();

        // Flush with the buffer full and a new input presented.
        out_ready = 1'b0;
        apply_stimulus(32'h00100093, 32'h0, 32'h1, 32'h0, mk(Add, 32'h1, 32'd1, 1'b0, 5'd1, 1'b1, 1'b0));
`ifdef ALU_DEC_SKID_EN
        apply_stimulus(32'h00200113, 32'h0, 32'h2, 32'h0, mk(Add, 32'h2, 32'd2, 1'b0, 5'd2, 1'b1, 1'b0));
`endif
        in_valid = 1'b1;
        in_instr = 32'h00300193;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check_output("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("flush_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;

        // Flush on an empty stage drops an input even though in_ready is high.
        in_valid = 1'b1;
        in_instr = 32'h00400213;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("after_flush_out_valid", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset between edges with an entry held.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_instr    = 32'h00900493;
        in_rs1_data = 32'h77;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_output("pre_reset_out_valid", {31'b0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        check_output("async_reset_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("async_reset_out_a", out_a, 32'd0);
        check_output("async_reset_out_b", out_b, 32'd0);
        check_output("async_reset_flags", {25'b0, out_rd, out_rd_we, out_invert, out_illegal}, 32'd0);
        @(negedge clk);
        #2;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
        check_output("post_reset_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("final_scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
